// File: rtl/pbit_pkg.sv
// Purpose: shared defaults, collector FSM state type and saturating increment helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: NUM_OUT/CNT_W/FIFO/BURN/DECIMATE defaults, collect_state_t, sat_inc().
package pbit_pkg;

  localparam int unsigned NUM_OUT_DEF    = 8;
  localparam int unsigned CNT_W_DEF      = 16;
  localparam int unsigned FIFO_DEPTH_DEF = 16;
  localparam int unsigned BURN_IN_DEF    = 64;
  localparam int unsigned DECIMATE_DEF   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BURN    = 2'd1,
    COLLECT = 2'd2
  } collect_state_t;

  // Increment that sticks at the all-ones value of a 'width'-bit counter.
  // Callers widen their counter to 32 bits and truncate the result back.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? val : (val + 32'd1);
  endfunction

endpackage

// File: rtl/pbit_sample_collector_sync_fifo.sv
// Purpose: synchronous show-ahead FIFO; head entry is always presented on pop_dat.
// Latency: a push into an empty FIFO is visible on pop_dat/!empty the next cycle.
// Backpressure: full is reported; push while full is discarded unless a pop happens in the same cycle.
// Ports: clk, reset (sync, active high); push/push_dat write side; pop/pop_dat read side;
//        full, empty status. Pop on an empty FIFO is ignored.
module sync_fifo
  import pbit_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the index bits match.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  end

  always_comb begin
    pop_ok  = pop & ~empty;
    // A simultaneous pop frees the head slot, so a push into a full FIFO
    // lands in the slot being vacated.
    push_ok = push & (~full | pop_ok);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;

    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_dat;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  // Head is read straight from the storage flops; forced to zero when empty
  // so the stream data is clean between bursts.
  assign pop_dat = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/pbit_sample_collector.sv
// Purpose: per-sweep sampler of the p-bit output vector with burn-in, decimation, hit/drop statistics.
// Latency: sample pushed on the sweep_tick edge, on m_data/m_valid one cycle later if the FIFO was empty.
// Backpressure: valid/ready stream; with the FIFO full and no pop, new samples are dropped and counted.
// Ports: clk, reset (sync, active high); enable (rising edge starts a run, low stops);
//        sweep_tick/pbit_out sample strobe and data; target hit pattern;
//        m_valid/m_ready/m_data sample stream; sample_cnt/hit_cnt/drop_cnt saturating stats;
//        collecting high while capturing.
module pbit_sample_collector
  import pbit_pkg::*;
#(
  parameter int unsigned NUM_OUT    = NUM_OUT_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned BURN_IN    = BURN_IN_DEF,
  parameter int unsigned DECIMATE   = DECIMATE_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               sweep_tick,
  input  logic [NUM_OUT-1:0] pbit_out,
  input  logic [NUM_OUT-1:0] target,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [NUM_OUT-1:0] m_data,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [CNT_W-1:0]   drop_cnt,
  output logic               collecting
);

  localparam int unsigned BW = (BURN_IN < 2) ? 1 : $clog2(BURN_IN);
  localparam int unsigned DW = (DECIMATE < 1) ? 1 : $clog2(DECIMATE + 1);
  localparam logic [BW-1:0] BURN_LAST = BW'((BURN_IN > 0) ? (BURN_IN - 1) : 0);
  localparam logic [DW-1:0] DEC_LAST  = DW'(DECIMATE);

  collect_state_t   state_q, state_d;
  logic             enable_q, enable_d;
  logic [BW-1:0]    burn_q, burn_d;
  logic [DW-1:0]    dec_q, dec_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic en_rise;
  logic capture;
  logic pop_fire;
  logic fifo_full;
  logic fifo_empty;

  always_comb begin
    state_d      = state_q;
    enable_d     = enable;
    burn_d       = burn_q;
    dec_d        = dec_q;
    sample_cnt_d = sample_cnt_q;
    hit_cnt_d    = hit_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    capture      = 1'b0;

    en_rise  = enable & ~enable_q;
    pop_fire = m_ready & ~fifo_empty;

    if (!enable) begin
      // Dropping enable wins over everything, including a tick this cycle.
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (en_rise) begin
            state_d      = BURN;
            burn_d       = '0;
            dec_d        = '0;
            sample_cnt_d = '0;
            hit_cnt_d    = '0;
            drop_cnt_d   = '0;
          end
        end
        BURN: begin
          if (BURN_IN == 0) begin
            state_d = COLLECT;
            dec_d   = '0;
          end else if (sweep_tick) begin
            if (burn_q == BURN_LAST) begin
              state_d = COLLECT;
              burn_d  = '0;
              dec_d   = '0;
            end else begin
              burn_d = burn_q + 1'b1;
            end
          end
        end
        COLLECT: begin
          if (sweep_tick) begin
            // Capture on phase 0, then skip DECIMATE sweeps.
            capture = (dec_q == '0);
            dec_d   = (dec_q == DEC_LAST) ? '0 : (dec_q + 1'b1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (capture) begin
      sample_cnt_d = CNT_W'(sat_inc(32'(sample_cnt_q), CNT_W));
      if (pbit_out == target) begin
        hit_cnt_d = CNT_W'(sat_inc(32'(hit_cnt_q), CNT_W));
      end
      if (fifo_full && !pop_fire) begin
        drop_cnt_d = CNT_W'(sat_inc(32'(drop_cnt_q), CNT_W));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      enable_q     <= 1'b0;
      burn_q       <= '0;
      dec_q        <= '0;
      sample_cnt_q <= '0;
      hit_cnt_q    <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      enable_q     <= enable_d;
      burn_q       <= burn_d;
      dec_q        <= dec_d;
      sample_cnt_q <= sample_cnt_d;
      hit_cnt_q    <= hit_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  sync_fifo #(
    .WIDTH (NUM_OUT),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (capture),
    .push_dat (pbit_out),
    .pop      (m_ready),
    .pop_dat  (m_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign m_valid    = ~fifo_empty;
  assign sample_cnt = sample_cnt_q;
  assign hit_cnt    = hit_cnt_q;
  assign drop_cnt   = drop_cnt_q;
  assign collecting = (state_q == COLLECT);

endmodule

// File: tb/tb_pbit_sample_collector.sv
// Bench for pbit_sample_collector: two instances (DECIMATE=2/16-bit counters and
// DECIMATE=0/4-bit counters, both BURN_IN=4, FIFO_DEPTH=4) checked every cycle
// against a queue-level model, plus table-driven and directed corner cases.
module tb_pbit_sample_collector;

  localparam int BURN  = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [1:0] en;
  logic       sweep_tick;
  logic [7:0] pbit_out;
  logic [7:0] target;
  logic       m_ready;

  logic        v0, v1, c0, c1;
  logic [7:0]  d0, d1;
  logic [15:0] s0, h0, dr0;
  logic [3:0]  s1, h1, dr1;

  int n_chk  = 0;
  int n_fail = 0;

  pbit_sample_collector #(
    .NUM_OUT(8), .FIFO_DEPTH(DEPTH), .BURN_IN(BURN), .DECIMATE(2), .CNT_W(16)
  ) u_dec2 (
    .clk(clk), .reset(reset), .enable(en[0]), .sweep_tick(sweep_tick),
    .pbit_out(pbit_out), .target(target), .m_valid(v0), .m_ready(m_ready),
    .m_data(d0), .sample_cnt(s0), .hit_cnt(h0), .drop_cnt(dr0), .collecting(c0)
  );

  pbit_sample_collector #(
    .NUM_OUT(8), .FIFO_DEPTH(DEPTH), .BURN_IN(BURN), .DECIMATE(0), .CNT_W(4)
  ) u_dec0 (
    .clk(clk), .reset(reset), .enable(en[1]), .sweep_tick(sweep_tick),
    .pbit_out(pbit_out), .target(target), .m_valid(v1), .m_ready(m_ready),
    .m_data(d1), .sample_cnt(s1), .hit_cnt(h1), .drop_cnt(dr1), .collecting(c1)
  );

  // Reference model: a run is "active" from the cycle after an enable rise
  // until enable drops; sweeps are numbered from the run start, the first
  // BURN are discarded and every (dec+1)-th after that is captured.
  int         dec_of [2] = '{2, 0};
  int         max_of [2] = '{65535, 15};
  bit         m_act  [2];
  bit         m_prev [2];
  int         m_ticks[2];
  int         m_size [2];
  int         m_samp [2];
  int         m_hit  [2];
  int         m_drop [2];
  logic [7:0] m_q    [2][DEPTH];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      bit cap;
      bit pop_ok;
      if (reset) begin
        m_act[i] = 0; m_prev[i] = 0; m_ticks[i] = 0; m_size[i] = 0;
        m_samp[i] = 0; m_hit[i] = 0; m_drop[i] = 0;
      end else begin
        cap    = 0;
        pop_ok = m_ready && (m_size[i] > 0);
        if (!en[i]) begin
          m_act[i] = 0;
        end else if (!m_prev[i] && !m_act[i]) begin
          m_act[i] = 1; m_ticks[i] = 0; m_samp[i] = 0; m_hit[i] = 0; m_drop[i] = 0;
        end else if (m_act[i] && sweep_tick) begin
          if (m_ticks[i] >= BURN && ((m_ticks[i] - BURN) % (dec_of[i] + 1)) == 0) cap = 1;
          m_ticks[i]++;
        end
        if (pop_ok) begin
          for (int k = 0; k < DEPTH - 1; k++) m_q[i][k] = m_q[i][k+1];
          m_size[i]--;
        end
        if (cap) begin
          if (m_samp[i] < max_of[i]) m_samp[i]++;
          if (pbit_out == target && m_hit[i] < max_of[i]) m_hit[i]++;
          if (m_size[i] < DEPTH) begin
            m_q[i][m_size[i]] = pbit_out;
            m_size[i]++;
          end else if (m_drop[i] < max_of[i]) begin
            m_drop[i]++;
          end
        end
        m_prev[i] = en[i];
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      logic [31:0] av, ad, as, ah, adr, ac;
      if (i == 0) begin
        av = 32'(v0); ad = 32'(d0); as = 32'(s0); ah = 32'(h0); adr = 32'(dr0); ac = 32'(c0);
      end else begin
        av = 32'(v1); ad = 32'(d1); as = 32'(s1); ah = 32'(h1); adr = 32'(dr1); ac = 32'(c1);
      end
      chk($sformatf("model%0d m_valid", i), av, 32'(m_size[i] > 0));
      chk($sformatf("model%0d m_data", i), ad, 32'((m_size[i] > 0) ? m_q[i][0] : 8'h00));
      chk($sformatf("model%0d sample_cnt", i), as, 32'(m_samp[i]));
      chk($sformatf("model%0d hit_cnt", i), ah, 32'(m_hit[i]));
      chk($sformatf("model%0d drop_cnt", i), adr, 32'(m_drop[i]));
      chk($sformatf("model%0d collecting", i), ac, 32'(m_act[i] && m_ticks[i] >= BURN));
    end
  endtask

  // One clock: model follows the edge, outputs checked on the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic tick_cyc(input logic [7:0] p);
    sweep_tick = 1'b1;
    pbit_out   = p;
    cyc();
    sweep_tick = 1'b0;
  endtask

  typedef struct {
    logic       en;
    logic       tick;
    logic [7:0] pbit;
    logic       exp_v;
    logic [7:0] exp_d;
    logic [3:0] exp_s;
    logic       exp_c;
  } vec_t;

  vec_t       tbl [8];
  logic [7:0] exp_dec [3];
  logic [7:0] exp_full [4];

  initial begin
    // Burn-in and capture on the DECIMATE=0 instance, ready held low.
    tbl[0] = '{1'b1, 1'b0, 8'h5A, 1'b0, 8'h00, 4'd0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 8'h5A, 1'b0, 8'h00, 4'd0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 8'h5A, 1'b0, 8'h00, 4'd0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 8'h5A, 1'b0, 8'h00, 4'd0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 8'h5A, 1'b0, 8'h00, 4'd0, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 8'h5A, 1'b1, 8'h5A, 4'd1, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 8'h5A, 1'b1, 8'h5A, 4'd2, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 8'h5A, 1'b1, 8'h5A, 4'd2, 1'b1};
    exp_dec  = '{8'h3C, 8'h11, 8'h3C};
    exp_full = '{8'h02, 8'h03, 8'h04, 8'h07};

    reset = 1'b1; en = 2'b00; sweep_tick = 1'b0; pbit_out = 8'h00; target = 8'h00; m_ready = 1'b0;
    cyc();
    cyc();
    chk("reset m_valid", 32'(v0), 32'd0);
    chk("reset m_data", 32'(d0), 32'd0);
    chk("reset sample_cnt", 32'(s0), 32'd0);
    chk("reset collecting", 32'(c1), 32'd0);
    reset = 1'b0;
    cyc();

    // Table: BURN_IN=4, DECIMATE=0, six ticks of 0x5A.
    for (int j = 0; j < 8; j++) begin
      en[1]      = tbl[j].en;
      sweep_tick = tbl[j].tick;
      pbit_out   = tbl[j].pbit;
      cyc();
      chk($sformatf("tbl[%0d] m_valid", j), 32'(v1), 32'(tbl[j].exp_v));
      chk($sformatf("tbl[%0d] m_data", j), 32'(d1), 32'(tbl[j].exp_d));
      chk($sformatf("tbl[%0d] sample_cnt", j), 32'(s1), 32'(tbl[j].exp_s));
      chk($sformatf("tbl[%0d] collecting", j), 32'(c1), 32'(tbl[j].exp_c));
    end
    sweep_tick = 1'b0;
    en[1] = 1'b0; m_ready = 1'b1;
    cyc();
    chk("drain1 m_data", 32'(d1), 32'h5A);
    chk("stop collecting", 32'(c1), 32'd0);
    cyc();
    chk("drain2 m_valid", 32'(v1), 32'd0);
    m_ready = 1'b0;

    // Decimation on the DECIMATE=2 instance: captures on ticks 1,4,7.
    target = 8'h3C; en[0] = 1'b1;
    cyc();
    for (int k = 0; k < 4; k++) begin
      tick_cyc(8'h00);
      chk($sformatf("burn%0d collecting", k), 32'(c0), 32'(k == 3));
    end
    for (int k = 1; k <= 9; k++) tick_cyc((k % 2 == 1) ? 8'h3C : 8'h11);
    chk("dec sample_cnt", 32'(s0), 32'd3);
    chk("dec hit_cnt", 32'(h0), 32'd2);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dec head%0d m_valid", k), 32'(v0), 32'd1);
      chk($sformatf("dec head%0d m_data", k), 32'(d0), 32'(exp_dec[k]));
      m_ready = 1'b1;
      cyc();
      m_ready = 1'b0;
    end
    chk("dec drained m_valid", 32'(v0), 32'd0);

    // Enable low with a capturing tick in the same cycle.
    tick_cyc(8'h77);
    tick_cyc(8'h78);
    tick_cyc(8'h79);
    en[0] = 1'b0;
    tick_cyc(8'h99);
    chk("stop sample_cnt", 32'(s0), 32'd4);
    chk("stop collecting", 32'(c0), 32'd0);
    chk("stop head", 32'(d0), 32'h77);
    m_ready = 1'b1;
    cyc();
    m_ready = 1'b0;
    chk("stop drained", 32'(v0), 32'd0);
    en[0] = 1'b1;
    cyc();
    chk("rerun sample_cnt", 32'(s0), 32'd0);
    chk("rerun hit_cnt", 32'(h0), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick_cyc(8'h00);
      chk($sformatf("reburn%0d collecting", k), 32'(c0), 32'(k == 3));
    end
    en[0] = 1'b0;
    cyc();

    // Full FIFO with ready low: head stays put, extra samples dropped.
    target = 8'h00; en[1] = 1'b1;
    cyc();
    for (int k = 0; k < 4; k++) tick_cyc(8'h00);
    for (int k = 1; k <= 6; k++) begin
      tick_cyc(8'(k));
      chk($sformatf("full%0d head", k), 32'(d1), 32'h01);
    end
    chk("full drop_cnt", 32'(dr1), 32'd2);
    chk("full sample_cnt", 32'(s1), 32'd6);

    // Push and pop together while full: no drop, head advances.
    m_ready = 1'b1;
    tick_cyc(8'h07);
    m_ready = 1'b0;
    chk("pushpop drop_cnt", 32'(dr1), 32'd2);
    chk("pushpop head", 32'(d1), 32'h02);
    tick_cyc(8'h08);
    chk("still full drop_cnt", 32'(dr1), 32'd3);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("full drain%0d", k), 32'(d1), 32'(exp_full[k]));
      m_ready = 1'b1;
      cyc();
      m_ready = 1'b0;
    end
    chk("full drained", 32'(v1), 32'd0);

    // Saturation of the 4-bit counters, then reset mid-run.
    en[1] = 1'b0;
    cyc();
    target = 8'hAB; en[1] = 1'b1; m_ready = 1'b1;
    cyc();
    for (int k = 0; k < 4; k++) tick_cyc(8'h00);
    for (int k = 1; k <= 17; k++) begin
      tick_cyc(8'hAB);
      if (k == 14) chk("sat hit_cnt 14", 32'(h1), 32'd14);
    end
    chk("sat hit_cnt", 32'(h1), 32'd15);
    chk("sat sample_cnt", 32'(s1), 32'd15);
    m_ready = 1'b0;
    tick_cyc(8'hAB);
    reset = 1'b1;
    cyc();
    chk("midreset m_valid", 32'(v1), 32'd0);
    chk("midreset hit_cnt", 32'(h1), 32'd0);
    chk("midreset collecting", 32'(c1), 32'd0);
    reset = 1'b0; en = 2'b00;
    cyc();

    // Random traffic against the model.
    en = 2'b11; target = 8'hC3;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < 2; i++) if ($urandom_range(0, 39) == 0) en[i] = ~en[i];
      sweep_tick = 1'($urandom_range(0, 1));
      pbit_out   = ($urandom_range(0, 2) == 0) ? target : 8'($urandom);
      m_ready    = ($urandom_range(0, 2) == 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
